serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 2..32.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_start  input  1  request; sampled only while idle.
REQ-005 i_sub  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with i_start.
REQ-006 i_a  input  WIDTH  operand A; sampled with i_start.
REQ-007 i_b  input  WIDTH  operand B; sampled with i_start.
REQ-008 o_busy  output  1  high while an operation is in RUN.
REQ-009 o_done  output  1  one-cycle pulse; result outputs are updated in this cycle.
REQ-010 o_result  output  WIDTH  sum/difference, held until next o_done.
REQ-011 o_cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-012 o_ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-013 FSM shall have two states: IDLE and RUN.
REQ-014 IDLE with i_start=1 at a rising edge shall load i_a, i_b XOR {WIDTH{i_sub}}, carry flop = i_sub, bit counter = 0, and enter RUN.
REQ-015 In RUN, each edge shall add the LSB of the A and B shift registers plus the carry flop through one full-adder cell, shift the sum bit into the result register MSB, shift both operand registers right, and store cout in the carry flop.
REQ-016 On the edge with counter = WIDTH-1, the block shall latch o_result, o_cout = adder cout, o_ovf = carry-in XOR carry-out of that MSB bit, pulse o_done, and return to IDLE.
REQ-017 Latency: o_done shall be high exactly WIDTH cycles after the edge that accepted i_start; throughput one operation per WIDTH cycles.
REQ-018 i_start while in RUN shall be ignored; no queuing.
REQ-019 i_start in the o_done cycle, when the FSM is IDLE, shall be accepted.
REQ-020 o_result, o_cout, and o_ovf shall not change outside o_done cycles.
REQ-021 Results are modulo 2^WIDTH; the counter width shall be clog2(WIDTH).

Reset
REQ-022 i_rst_n=0 shall immediately force IDLE, o_busy=0, o_done=0, o_result=0, o_cout=0, o_ovf=0, and counter/carry/shift registers to 0.
REQ-023 Reset mid-RUN shall abort the operation without an o_done pulse; the first i_start after release shall be accepted normally.

Structure
REQ-024 State encoding localparams (IDLE, RUN) shall reside in shared package add_sub_pkg.
REQ-025 The per-bit add shall instantiate the team's existing fa full-adder cell once; no other sub-modules.

Verification (WIDTH=4)
REQ-026 A=3, B=5, sub=0 -> o_done 4 cycles after start, result=4'b1000, cout=0, ovf=1.
REQ-027 A=7, B=2, sub=1 -> result=4'b0101, cout=1, ovf=0.
REQ-028 A=2, B=3, sub=1 -> result=4'b1111, cout=0, ovf=0.
REQ-029 A=15, B=1, sub=0 -> result=0, cout=1, ovf=0.
REQ-030 Start at cycle 0, second start at cycle 2 -> second ignored, single o_done; start in the o_done cycle -> accepted.
REQ-031 Assert reset at cycle 2 of RUN -> all outputs 0 at once, no o_done; next op A=1, B=1, add -> result=2.

Source files
------------

// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_pkg
//  Purpose  : Shared definitions for the bit-serial adder/subtractor.
//             Holds the FSM state type and its encodings.
//  Contents : state_t   - FSM state register type
//             c_st_idle - waiting for i_start
//             c_st_run  - one operand bit processed per clock
//  Revision : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

    localparam int unsigned STATE_W = 1;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_st_idle = 1'b0;
    localparam state_t c_st_run  = 1'b1;

endpackage : add_sub_pkg
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
//  Module   : fa
//  Purpose  : Single-bit full-adder cell.
//  Ports    : i_a, i_b - addend bits
//             i_cin    - carry in
//             o_s      - sum bit
//             o_cout   - carry out
//  Revision : 1.0 - initial release
// ============================================================================
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : fa
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_sub
//  Purpose  : Bit-serial two's-complement adder/subtractor. One operand bit
//             is processed per clock through a single full-adder cell;
//             a WIDTH-bit operation completes in WIDTH cycles.
//  Params   : WIDTH    - operand/result width (2..32)
//  Ports    : i_clk    - clock, rising edge
//             i_rst_n  - asynchronous active-low reset
//             i_start  - request, sampled only while idle
//             i_sub    - 0 = A+B, 1 = A-B (sampled with i_start)
//             i_a/i_b  - operands (sampled with i_start)
//             o_busy   - operation in progress
//             o_done   - one-cycle pulse, results valid/updated this cycle
//             o_result - sum/difference modulo 2^WIDTH, held between dones
//             o_cout   - final carry (subtract: 1 = no borrow)
//             o_ovf    - signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;

    logic               w_s;
    logic               w_co;

    fa u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Subtraction is A + ~B + 1: B is inverted at load and the
    // carry flop is seeded with i_sub.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_a     <= i_a;
                r_b     <= i_b ^ {WIDTH{i_sub}};
                r_carry <= i_sub;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                r_carry <= w_co;
                r_cnt   <= r_cnt + c_one;
            end
            // The last sum bit is still combinational here, so the final
            // result is assembled directly rather than from r_sum.
            if (w_finish) begin
                r_result <= {w_s, r_sum[WIDTH-1:1]};
                r_cout   <= w_co;
                r_ovf    <= r_carry ^ w_co;
            end
        end
    end

    assign o_busy   = (r_state == c_st_run);
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_ovf    = r_ovf;

endmodule : serial_add_sub
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_sub
//  Purpose  : Self-checking bench for serial_add_sub (WIDTH=4). Directed
//             operations push expected results into a queue; a monitor
//             pops and compares on each o_done and checks output hold.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int               checks   = 0;
    int               failures = 0;
    int               edge_cnt = 0;

    exp_t             sb[$];
    exp_t             e_mon;
    logic [WIDTH-1:0] ref_r;
    logic             ref_c;
    logic             ref_v;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_sub    (sub),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_cout   (cout),
        .o_ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: compare on o_done, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            ref_r = '0;
            ref_c = 1'b0;
            ref_v = 1'b0;
        end else if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done result=%0h cout=%0b ovf=%0b", result, cout, ovf);
            end else begin
                e_mon = sb.pop_front();
                checks++;
                if (result !== e_mon.r || cout !== e_mon.c || ovf !== e_mon.v || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL result got r=%0h c=%0b v=%0b busy=%0b exp r=%0h c=%0b v=%0b busy=0",
                             result, cout, ovf, busy, e_mon.r, e_mon.c, e_mon.v);
                end
                checks++;
                if (edge_cnt != e_mon.due) begin
                    failures++;
                    $display("FAIL latency done_edge=%0d exp=%0d", edge_cnt, e_mon.due);
                end
            end
            ref_r = result;
            ref_c = cout;
            ref_v = ovf;
        end else begin
            checks++;
            if ({result, cout, ovf} !== {ref_r, ref_c, ref_v}) begin
                failures++;
                $display("FAIL hold got r=%0h c=%0b v=%0b exp r=%0h c=%0b v=%0b",
                         result, cout, ovf, ref_r, ref_c, ref_v);
            end
        end
    end

    // Drive a request at the current negedge; deasserted at the next one.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic ts, input logic [WIDTH-1:0] er,
                         input logic ec, input logic ev, input bit push);
        exp_t e;
        start = 1'b1;
        a     = ta;
        b     = tb;
        sub   = ts;
        if (push) begin
            e.r   = er;
            e.c   = ec;
            e.v   = ev;
            e.due = edge_cnt + 1 + WIDTH;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%0b exp=1", busy);
        end
    endtask

    // Returns at the negedge where o_done is seen.
    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 3 * WIDTH + 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout got=%0b exp=1", done);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%0h exp=0", {busy, done, result, cout, ovf});
        end
        rst_n = 1'b1;

        // Basic vectors
        @(negedge clk); issue(4'd3,  4'd5, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1); wait_done();
        @(negedge clk); issue(4'd7,  4'd2, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1); wait_done();
        @(negedge clk); issue(4'd2,  4'd3, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1); wait_done();
        @(negedge clk); issue(4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1); wait_done();
        @(negedge clk); issue(4'd8,  4'd1, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b1); wait_done();

        // Start during RUN is ignored; start in the done cycle is accepted
        @(negedge clk); issue(4'd4, 4'd3, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
        start = 1'b1; a = 4'd1; b = 4'd1; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(4'd9, 4'd9, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
        wait_done();

        // Reset in the middle of RUN aborts without a done pulse
        @(negedge clk); issue(4'd6, 4'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            failures++;
            $display("FAIL mid_run_reset got=%0h exp=0", {busy, done, result, cout, ovf});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 2) @(negedge clk);
        issue(4'd1, 4'd1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_sub
`default_nettype wire
